// File: rtl/_gcd_binary_if.sv
// Handshake bundle for the binary GCD engine.
// Optional _cycles member exists only with GCD_CYCLE_COUNT_EN.
interface _gcd_binary_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(3*WIDTH+4);

    logic             _start;
    logic [WIDTH-1:0] _num0;
    logic [WIDTH-1:0] _num1;
    logic             _busy;
    logic             _success;
    logic [WIDTH-1:0] _greatest;
`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_W-1:0] _cycles;
`endif

    modport master (
        output _start, _num0, _num1,
        input  _busy, _success, _greatest
`ifdef GCD_CYCLE_COUNT_EN
        , input _cycles
`endif
    );

    modport slave (
        input  _start, _num0, _num1,
        output _busy, _success, _greatest
`ifdef GCD_CYCLE_COUNT_EN
        , output _cycles
`endif
    );
endinterface

// File: rtl/_gcd_binary.sv
// WIDTH-generic binary (Stein) GCD engine with busy/success handshake.
// GCD_CYCLE_COUNT_EN adds the _cycles latency report.
module _gcd_binary #(
    parameter int WIDTH = 8
) (
    input  logic         _clock,
    input  logic         _reset,
    _gcd_binary_if.slave bus
);
    localparam int KW    = $clog2(WIDTH+1);
    localparam int CNT_W = $clog2(3*WIDTH+4);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REDUCE,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    k;
    logic             zero_op;

`ifdef GCD_CYCLE_COUNT_EN
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
    logic [CNT_W-1:0] cnt;
`endif

    assign zero_op = (bus._num0 == '0) || (bus._num1 == '0);

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state         <= IDLE;
            a             <= '0;
            b             <= '0;
            k             <= '0;
            bus._busy     <= 1'b0;
            bus._success  <= 1'b0;
            bus._greatest <= '0;
`ifdef GCD_CYCLE_COUNT_EN
            cnt           <= '0;
            bus._cycles   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus._start) begin
                        a <= bus._num0;
                        b <= bus._num1;
                        k <= '0;
`ifdef GCD_CYCLE_COUNT_EN
                        cnt <= '0;
`endif
                        if (zero_op) begin
                            bus._greatest <= bus._num0 | bus._num1;
                            bus._success  <= 1'b1;
                            state         <= DONE;
`ifdef GCD_CYCLE_COUNT_EN
                            bus._cycles   <= ONE;
`endif
                        end else begin
                            bus._busy <= 1'b1;
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
`ifdef GCD_CYCLE_COUNT_EN
                    cnt <= cnt + ONE;
`endif
                    if (!a[0] && !b[0]) begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + 1'b1;
                    end else begin
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
`ifdef GCD_CYCLE_COUNT_EN
                    cnt <= cnt + ONE;
`endif
                    // Subtraction only sees unequal odd values, so a,b stay nonzero.
                    if (a == b) begin
                        bus._greatest <= a << k;
                        bus._busy     <= 1'b0;
                        bus._success  <= 1'b1;
                        state         <= DONE;
`ifdef GCD_CYCLE_COUNT_EN
                        bus._cycles   <= cnt + TWO;
`endif
                    end else if (!a[0]) begin
                        a <= a >> 1;
                    end else if (!b[0]) begin
                        b <= b >> 1;
                    end else if (a > b) begin
                        a <= a - b;
                    end else begin
                        b <= b - a;
                    end
                end
                DONE: begin
                    bus._success <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb__gcd_binary.sv
// Directed self-checking bench for _gcd_binary (WIDTH 8 and 16).
module tb__gcd_binary;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   sel = 0;

    always #5 clk = ~clk;

    _gcd_binary_if #(.WIDTH(8))  b8 ();
    _gcd_binary_if #(.WIDTH(16)) b16 ();

    _gcd_binary #(.WIDTH(8)) u8 (
        ._clock (clk),
        ._reset (rst_n),
        .bus    (b8)
    );

    _gcd_binary #(.WIDTH(16)) u16 (
        ._clock (clk),
        ._reset (rst_n),
        .bus    (b16)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic succ();
        return (sel != 0) ? b16._success : b8._success;
    endfunction

    function automatic logic bsy();
        return (sel != 0) ? b16._busy : b8._busy;
    endfunction

    function automatic logic [63:0] gr();
        return (sel != 0) ? 64'(b16._greatest) : 64'(b8._greatest);
    endfunction

    task automatic drive(input logic [63:0] n0, input logic [63:0] n1,
                         input logic st);
        if (sel != 0) begin
            b16._start = st;
            b16._num0  = n0[15:0];
            b16._num1  = n1[15:0];
        end else begin
            b8._start = st;
            b8._num0  = n0[7:0];
            b8._num1  = n1[7:0];
        end
    endtask

    task automatic wait_done(input int budget, output int lat,
                             output logic sawbusy);
        lat = 0;
        sawbusy = bsy();
        while (!succ() && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
            sawbusy = sawbusy | bsy();
        end
        check("success_seen", 64'(succ()), 64'd1);
    endtask

    // Called #1 after an edge with the DUT in IDLE.
    task automatic run(input string tag, input logic [63:0] n0,
                       input logic [63:0] n1, input logic [63:0] expg,
                       input int explat, input int budget,
                       output logic sawbusy);
        int lat;
        drive(n0, n1, 1'b1);
        @(posedge clk);
        #1;
        drive(n0, n1, 1'b0);
        wait_done(budget, lat, sawbusy);
        check({tag, "_gcd"}, gr(), expg);
        if (explat >= 0)
            check({tag, "_lat"}, 64'(lat), 64'(explat));
        else
            check({tag, "_lat_bound"}, 64'(lat <= budget), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_pulse1"}, 64'(succ()), 64'd0);
    endtask

    initial begin
        int   lat;
        logic sb;
        logic seen;
        b8._start  = 1'b0; b8._num0  = '0; b8._num1  = '0;
        b16._start = 1'b0; b16._num0 = '0; b16._num1 = '0;

        #12;
        check("rst_busy", 64'(b8._busy), 64'd0);
        check("rst_success", 64'(b8._success), 64'd0);
        check("rst_greatest", 64'(b8._greatest), 64'd0);
`ifdef GCD_CYCLE_COUNT_EN
        check("rst_cycles", 64'(b8._cycles), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("g36_24", 36, 24, 12, 7, 40, sb);
        check("g36_24_busy", 64'(sb), 64'd1);
`ifdef GCD_CYCLE_COUNT_EN
        check("g36_24_cycles", 64'(b8._cycles), 64'd8);
`endif
        run("g0_5", 0, 5, 5, 0, 40, sb);
        check("g0_5_busy", 64'(sb), 64'd0);
`ifdef GCD_CYCLE_COUNT_EN
        check("g0_5_cycles", 64'(b8._cycles), 64'd1);
`endif
        run("g0_0", 0, 0, 0, 0, 40, sb);
        check("g0_0_busy", 64'(sb), 64'd0);
        run("g7_7", 7, 7, 7, 2, 40, sb);
        run("g17_5", 17, 5, 1, -1, 27, sb);

        // New request while busy must be ignored.
        drive(36, 24, 1'b1);
        @(posedge clk);
        #1;
        drive(7, 7, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        drive(7, 7, 1'b0);
        wait_done(30, lat, sb);
        check("ignore_gcd", gr(), 64'd12);
        @(posedge clk);
        #1;

        // Held start: second op sampled after DONE->IDLE.
        drive(17, 5, 1'b1);
        @(posedge clk);
        #1;
        wait_done(30, lat, sb);
        check("held_first", gr(), 64'd1);
        drive(7, 7, 1'b1);
        @(posedge clk);
        #1;
        check("held_gap", 64'(succ()), 64'd0);
        check("held_gap_busy", 64'(bsy()), 64'd0);
        @(posedge clk);
        #1;
        check("held_busy", 64'(bsy()), 64'd1);
        wait_done(30, lat, sb);
        check("held_second", gr(), 64'd7);
        check("held_second_lat", 64'(lat), 64'd2);
        drive(7, 7, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous abort during REDUCE.
        drive(36, 24, 1'b1);
        @(posedge clk);
        #1;
        drive(36, 24, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy_pre", 64'(bsy()), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(b8._busy), 64'd0);
        check("abort_success", 64'(b8._success), 64'd0);
        check("abort_greatest", 64'(b8._greatest), 64'd0);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen = seen | b8._success;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen = seen | b8._success;
        end
        check("abort_no_success", 64'(seen), 64'd0);
        run("post_rst", 36, 24, 12, 7, 40, sb);

        sel = 1;
        run("w16_a", 48000, 18000, 6000, -1, 51, sb);
        run("w16_b", 65535, 255, 255, -1, 51, sb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
